// File: rtl/digital_lock_pkg.sv
// Shared definitions for the digital lock key bus.
// Holds the key width and idle value, the passcode player state encoding,
// and the one-hot digit check that both the player and the lock use.
package digital_lock_pkg;

  localparam int unsigned KEY_WIDTH = 4;
  localparam logic [KEY_WIDTH-1:0] KEY_NONE = 4'h0;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StGap,
    StSettle,
    StDone
  } player_state_e;

  // A digit is valid only with exactly one of its four bits set.
  function automatic logic is_onehot4(input logic [KEY_WIDTH-1:0] digit);
    return $countones(digit) == 1;
  endfunction

endpackage

// File: rtl/passcode_player.sv
// Key-entry transmitter for the digital lock key bus.
// Plays a captured passcode onto key as timed press/release pulses.
// Ports:
//   clock    - single clock
//   reset    - synchronous, active-high reset
//   start    - request to play passcode (sampled only when idle)
//   passcode - PASSCODE_LENGTH one-hot nibbles, MSB nibble played first
//   key      - registered one-hot keypress, or KEY_NONE
//   busy     - high while a sequence is in progress
//   done     - one-cycle pulse at sequence completion
//   error    - one-cycle pulse when start is rejected for a bad digit
module passcode_player
  import digital_lock_pkg::*;
#(
  parameter int unsigned PASSCODE_LENGTH = 3,
  parameter int unsigned PRESS_CYCLES    = 1,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned SETTLE_CYCLES   = 5
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [KEY_WIDTH*PASSCODE_LENGTH-1:0] passcode,
  output logic [KEY_WIDTH-1:0]                 key,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int unsigned CodeW = KEY_WIDTH * PASSCODE_LENGTH;
  localparam int unsigned MaxPg = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCycles = (MaxPg > SETTLE_CYCLES) ? MaxPg : SETTLE_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;
  localparam int unsigned IdxW = (PASSCODE_LENGTH > 1) ? $clog2(PASSCODE_LENGTH) : 1;

  localparam logic [CntW-1:0] PressLoad  = CntW'(PRESS_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad    = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(PASSCODE_LENGTH - 1);

  player_state_e    state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [CodeW-1:0] shift_q;
  logic             all_onehot;

  always_comb begin
    all_onehot = 1'b1;
    for (int i = 0; i < int'(PASSCODE_LENGTH); i++) begin
      if (!is_onehot4(passcode[i*KEY_WIDTH +: KEY_WIDTH])) begin
        all_onehot = 1'b0;
      end
    end
  end

  // State, counter, shift register and output registers share one block so
  // every output changes on the same edge as the state that implies it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      key     <= KEY_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (all_onehot) begin
              // Digit 0 goes straight to key; the rest wait in shift_q's top nibble.
              key     <= passcode[CodeW-1 -: KEY_WIDTH];
              shift_q <= passcode << KEY_WIDTH;
              idx_q   <= '0;
              cnt_q   <= PressLoad;
              busy    <= 1'b1;
              state_q <= StPress;
            end else begin
              error <= 1'b1;
            end
          end
        end
        StPress: begin
          if (cnt_q == '0) begin
            key     <= KEY_NONE;
            cnt_q   <= GapLoad;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (idx_q == LastIdx) begin
            if (SETTLE_CYCLES == 0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              cnt_q   <= SettleLoad;
              state_q <= StSettle;
            end
          end else begin
            idx_q   <= idx_q + 1'b1;
            key     <= shift_q[CodeW-1 -: KEY_WIDTH];
            shift_q <= shift_q << KEY_WIDTH;
            cnt_q   <= PressLoad;
            state_q <= StPress;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_player.sv
// Self-checking bench for passcode_player. Instance a uses default timing,
// instance b uses PRESS=3, GAP=2, SETTLE=0. Expected per-cycle outputs
// {key, busy, done, error} are queued from a timing model when stimulus is
// driven and popped as each cycle is observed.
module tb_passcode_player;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a;
  logic        start_b;
  logic [11:0] passcode;
  logic [3:0]  key_a, key_b;
  logic        busy_a, busy_b, done_a, done_b, error_a, error_b;

  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [6:0] got, want;

  always #5 clock = ~clock;

  passcode_player dut_a (
    .clock    (clock),
    .reset    (reset),
    .start    (start_a),
    .passcode (passcode),
    .key      (key_a),
    .busy     (busy_a),
    .done     (done_a),
    .error    (error_a)
  );

  passcode_player #(
    .PASSCODE_LENGTH (3),
    .PRESS_CYCLES    (3),
    .GAP_CYCLES      (2),
    .SETTLE_CYCLES   (0)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .start    (start_b),
    .passcode (passcode),
    .key      (key_b),
    .busy     (busy_b),
    .done     (done_b),
    .error    (error_b)
  );

  function automatic logic [6:0] obs_a();
    return {key_a, busy_a, done_a, error_a};
  endfunction

  function automatic logic [6:0] obs_b();
    return {key_b, busy_b, done_b, error_b};
  endfunction

  // Cycle c (1-based) after an accepted start at edge k, i.e. the value seen
  // after edge k+c-1.
  task automatic push_play(input logic [11:0] pc, input int p, input int g, input int s,
                           input int first, input int last);
    for (int c = first; c <= last; c++) begin
      int n, r, total;
      logic [3:0] k;
      total = 3 * (p + g) + s;
      n = (c - 1) / (p + g);
      r = (c - 1) % (p + g);
      k = (n < 3 && r < p) ? pc[(2 - n) * 4 +: 4] : 4'h0;
      exp_q.push_back({k, (c >= 1 && c <= total), (c == total + 1), 1'b0});
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(7'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; passcode = 12'h000;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_a() !== 7'h00) begin
      failures++;
      $display("FAIL reset_a got=%h want=00", obs_a());
    end
    checks++;
    if (obs_b() !== 7'h00) begin
      failures++;
      $display("FAIL reset_b got=%h want=00", obs_b());
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_play();
    passcode = 12'h124; start_a = 1'b1;
    push_play(12'h124, 1, 1, 5, 1, 13);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clock);
      if (j == 1) start_a = 1'b0;
      got = obs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_play cycle=%0d got=%h want=%h", j, got, want);
      end
    end
  endtask

  task automatic test_reject();
    logic [11:0] bad[2];
    bad[0] = 12'h134; bad[1] = 12'h120;
    for (int t = 0; t < 2; t++) begin
      passcode = bad[t]; start_a = 1'b1;
      exp_q.push_back(7'h01);
      push_idle(3);
      for (int j = 1; j <= 4; j++) begin
        @(negedge clock);
        if (j == 1) start_a = 1'b0;
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL test_reject code=%h cycle=%0d got=%h want=%h", bad[t], j, got, want);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    passcode = 12'h124; start_a = 1'b1;
    push_play(12'h124, 1, 1, 5, 1, 13);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clock);
      if (j == 1) start_a = 1'b0;
      if (j == 2) passcode = 12'h842;
      if (j == 4) start_a = 1'b1;
      if (j == 5) start_a = 1'b0;
      got = obs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_start_ignored cycle=%0d got=%h want=%h", j, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    passcode = 12'h421; start_a = 1'b1;
    // Held start: DONE at cycle 12, idle at 13, restart accepted at edge k+13.
    push_play(12'h421, 1, 1, 5, 1, 13);
    push_play(12'h421, 1, 1, 5, 1, 13);
    for (int j = 1; j <= 26; j++) begin
      @(negedge clock);
      if (j == 14) start_a = 1'b0;
      got = obs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_back_to_back cycle=%0d got=%h want=%h", j, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    passcode = 12'h248; start_a = 1'b1;
    push_play(12'h248, 1, 1, 5, 1, 3);
    push_idle(2);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clock);
      if (j == 1) start_a = 1'b0;
      if (j == 3) reset = 1'b1;
      if (j == 4) reset = 1'b0;
      got = obs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_reset_mid cycle=%0d got=%h want=%h", j, got, want);
      end
    end
    start_a = 1'b1;
    push_play(12'h248, 1, 1, 5, 1, 13);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clock);
      if (j == 1) start_a = 1'b0;
      got = obs_a(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_reset_replay cycle=%0d got=%h want=%h", j, got, want);
      end
    end
  endtask

  task automatic test_long_timing();
    passcode = 12'h881; start_b = 1'b1;
    push_play(12'h881, 3, 2, 0, 1, 17);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clock);
      if (j == 1) start_b = 1'b0;
      got = obs_b(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL test_long_timing cycle=%0d got=%h want=%h", j, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_play();
    test_reject();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_long_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
